// File: rtl/fire_pe_array_if.sv
// -----------------------------------------------------------------------------
// fire_pe_array_if
//   Stream bundle for the fire-module PE array.
//   Input stream : in_valid / in_ready carry one beat of act and wgt.
//   Output stream: out_valid / out_ready carry out_data and out_mask.
//   Handshake rule for both streams: a transfer happens on a rising clock edge
//   where valid and ready are both high. Once out_valid rises, out_data and
//   out_mask hold until that transfer. in_ready is high only while the array
//   is accumulating.
//   Modports: master = producer of beats / consumer of results (bench side),
//             slave  = the PE array.
// -----------------------------------------------------------------------------
interface fire_pe_array_if #(
   parameter int LANES  = 9,
   parameter int DATA_W = 8
);
   logic                      in_valid;
   logic                      in_ready;
   logic [LANES*DATA_W-1:0]   act;
   logic [LANES*DATA_W-1:0]   wgt;
   logic                      out_valid;
   logic                      out_ready;
   logic [LANES*DATA_W-1:0]   out_data;
   logic [LANES-1:0]          out_mask;

   modport master (
      output in_valid, act, wgt, out_ready,
      input  in_ready, out_valid, out_data, out_mask
   );

   modport slave (
      input  in_valid, act, wgt, out_ready,
      output in_ready, out_valid, out_data, out_mask
   );
endinterface

// File: rtl/fire_pe_array.sv
// -----------------------------------------------------------------------------
// fire_pe_array
//   Self-sequencing multiply-accumulate array for the SqueezeNet fire module.
//   A job is launched with start (mode, num_ch and bias captured), accumulates
//   num_ch beats, rounds and saturates each active accumulator into an 8-bit
//   result and presents it on the output stream.
//     mode 0 (pointwise): every lane independent, weight lane 0 broadcast.
//     mode 1 (3x3 window): all lane products reduced into lane 0.
//   Optional build macro: FIRE_PE_RELU_EN -- clamps negative rounded results
//   to zero before output saturation.
//   Ports:
//     clk, rst_n          clock, asynchronous active-low reset
//     start, mode,        job launch and job configuration (sampled in IDLE)
//     num_ch, bias
//     busy                high whenever a job is in progress
//     dbg_state           current FSM state (IDLE=0, ACCUM=1, REQUANT=2, OUTPUT=3)
//     s                   stream bundle (fire_pe_array_if.slave)
// -----------------------------------------------------------------------------
module fire_pe_array #(
   parameter int LANES     = 9,
   parameter int DATA_W    = 8,
   parameter int ACC_W     = 24,
   parameter int CNT_W     = 9,
   parameter int OUT_SHIFT = 10
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic                    mode,
   input  logic [CNT_W-1:0]        num_ch,
   input  logic signed [ACC_W-1:0] bias,
   output logic                    busy,
   output logic [1:0]              dbg_state,
   fire_pe_array_if.slave          s
);

   typedef enum logic [1:0] {IDLE, ACCUM, REQUANT, OUTPUT} state_t;

   localparam logic signed [ACC_W+4:0] ACC_MAX = {{6{1'b0}}, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W+4:0] ACC_MIN = {{6{1'b1}}, {(ACC_W-1){1'b0}}};
   localparam logic signed [ACC_W:0]   OUT_MAX = {{(ACC_W+2-DATA_W){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W:0]   OUT_MIN = {{(ACC_W+2-DATA_W){1'b1}}, {(DATA_W-1){1'b0}}};
   localparam logic [ACC_W:0]          RND     = {{(ACC_W+1-OUT_SHIFT){1'b0}}, 1'b1, {(OUT_SHIFT-1){1'b0}}};
   localparam logic [CNT_W-1:0]        CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t                    state_q, state_d;
   logic                      mode_q;
   logic [CNT_W-1:0]          num_ch_q;
   logic [CNT_W-1:0]          cnt_q;
   logic [CNT_W-1:0]          cnt_inc;
   logic signed [ACC_W-1:0]   acc_q [LANES];
   logic signed [ACC_W-1:0]   acc_d [LANES];
   logic [LANES*DATA_W-1:0]   out_data_q;
   logic [LANES-1:0]          out_mask_q;
   logic signed [2*DATA_W-1:0] prod_pw  [LANES];
   logic signed [2*DATA_W-1:0] prod_win [LANES];
   logic signed [ACC_W+3:0]   win_sum;
   logic                      xfer;

   // Sign-extend a full-precision product to the window-sum width.
   function automatic logic signed [ACC_W+3:0] ext(input logic signed [2*DATA_W-1:0] p);
      return {{(ACC_W+4-2*DATA_W){p[2*DATA_W-1]}}, p};
   endfunction

   // Accumulate with clamping at the signed ACC_W limits instead of wrapping.
   function automatic logic signed [ACC_W-1:0] sat_add(input logic signed [ACC_W-1:0] a,
                                                       input logic signed [ACC_W+3:0] b);
      logic signed [ACC_W+4:0] sum;
      sum = {{5{a[ACC_W-1]}}, a} + {b[ACC_W+3], b};
      if (sum > ACC_MAX)      return ACC_MAX[ACC_W-1:0];
      else if (sum < ACC_MIN) return ACC_MIN[ACC_W-1:0];
      else                    return sum[ACC_W-1:0];
   endfunction

   // Round half up, arithmetic shift to output scale, optional ReLU, clamp.
   function automatic logic [DATA_W-1:0] requant(input logic signed [ACC_W-1:0] a);
      logic signed [ACC_W:0] t;
      logic signed [ACC_W:0] r;
      t = {a[ACC_W-1], a} + RND;
      r = t >>> OUT_SHIFT;
`ifdef FIRE_PE_RELU_EN
      if (r < 0) r = '0;
`endif
      if (r > OUT_MAX)      r = OUT_MAX;
      else if (r < OUT_MIN) r = OUT_MIN;
      return r[DATA_W-1:0];
   endfunction

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign prod_pw[l]  = $signed(s.act[l*DATA_W +: DATA_W]) * $signed(s.wgt[0 +: DATA_W]);
      assign prod_win[l] = $signed(s.act[l*DATA_W +: DATA_W]) * $signed(s.wgt[l*DATA_W +: DATA_W]);
   end

   assign xfer    = s.in_valid && (state_q == ACCUM);
   assign cnt_inc = cnt_q + CNT_ONE;

   // Next accumulator values for a transferring beat.
   always_comb begin
      win_sum = '0;
      for (int l = 0; l < LANES; l++) begin
         win_sum = win_sum + ext(prod_win[l]);
      end
      for (int l = 0; l < LANES; l++) begin
         acc_d[l] = acc_q[l];
      end
      if (!mode_q) begin
         for (int l = 0; l < LANES; l++) begin
            acc_d[l] = sat_add(acc_q[l], ext(prod_pw[l]));
         end
      end else begin
         acc_d[0] = sat_add(acc_q[0], win_sum);
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = (num_ch == '0) ? REQUANT : ACCUM;
         ACCUM:   if (xfer && (cnt_inc == num_ch_q)) state_d = REQUANT;
         REQUANT: state_d = OUTPUT;
         OUTPUT:  if (s.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         mode_q     <= 1'b0;
         num_ch_q   <= '0;
         cnt_q      <= '0;
         out_data_q <= '0;
         out_mask_q <= '0;
         for (int l = 0; l < LANES; l++) acc_q[l] <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (start) begin
                  mode_q   <= mode;
                  num_ch_q <= num_ch;
                  cnt_q    <= '0;
                  // Window mode seeds the bias into the single reduction lane.
                  for (int l = 0; l < LANES; l++) acc_q[l] <= (!mode || l == 0) ? bias : '0;
               end
            end
            ACCUM: begin
               if (xfer) begin
                  cnt_q <= cnt_inc;
                  for (int l = 0; l < LANES; l++) acc_q[l] <= acc_d[l];
               end
            end
            REQUANT: begin
               for (int l = 0; l < LANES; l++) begin
                  out_data_q[l*DATA_W +: DATA_W] <= (!mode_q || l == 0) ? requant(acc_q[l]) : '0;
               end
               out_mask_q <= mode_q ? {{(LANES-1){1'b0}}, 1'b1} : {LANES{1'b1}};
            end
            default: ;
         endcase
      end
   end

   assign s.in_ready  = (state_q == ACCUM);
   assign s.out_valid = (state_q == OUTPUT);
   assign s.out_data  = out_data_q;
   assign s.out_mask  = out_mask_q;
   assign busy        = (state_q != IDLE);
   assign dbg_state   = state_q;

endmodule
